// File: rtl/adder_tree_pipe.sv
// Pipelined signed adder tree: one register per reduction level, followed by an
// accumulate-and-reduce output stage. A global stall freezes every register.
module adder_tree_pipe #(
  parameter int unsigned DATA_WID  = 16,
  parameter int unsigned INPUT_NUM = 8,
  parameter bit          SAT       = 1'b1,
  parameter bit          ACC_EN    = 1'b1,
  parameter int unsigned ACC_GUARD = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       stall,
  input  logic                       in_valid,
  input  logic                       in_first,
  input  logic                       in_last,
  input  logic signed [DATA_WID-1:0] IN [0:INPUT_NUM-1],
  output logic                       out_valid,
  output logic signed [DATA_WID-1:0] OUT,
  output logic                       out_ovf
);

  localparam int unsigned L  = $clog2(INPUT_NUM);
  localparam int unsigned TW = DATA_WID + L;
  localparam int unsigned AW = TW + ACC_GUARD;

  function automatic int unsigned lvl_cnt(input int unsigned k);
    return (INPUT_NUM + (32'd1 << k) - 32'd1) >> k;
  endfunction

  // Bit offset of level k inside the flattened tree register.
  function automatic int unsigned lvl_off(input int unsigned k);
    int unsigned off;
    off = 0;
    for (int unsigned m = 1; m < k; m++) off += lvl_cnt(m) * (DATA_WID + m);
    return off;
  endfunction

  localparam int unsigned TREE_BITS = lvl_off(L + 1);
  localparam logic signed [AW-1:0] MAX_V = {{(AW-DATA_WID+1){1'b0}}, {(DATA_WID-1){1'b1}}};
  localparam logic signed [AW-1:0] MIN_V = ~MAX_V;

  logic [L-1:0]          vld_q, first_q, last_q;
  logic [L-1:0]          vld_d, first_d, last_d;
  logic [TREE_BITS-1:0]  tree_q, tree_d;
  logic signed [TW-1:0]  tree_sum;
  logic signed [AW-1:0]  acc_q, acc_d, acc_next_c;
  logic signed [DATA_WID-1:0] wrap_c, res_c;
  logic                  res_ovf_c;
  logic                  out_valid_q, out_valid_d;
  logic signed [DATA_WID-1:0] out_q, out_d;
  logic                  out_ovf_q, out_ovf_d;

  // Flags shift one level per unstalled cycle; without accumulation every beat is its own group.
  assign vld_d   = L'({vld_q, in_valid});
  assign first_d = L'({first_q, (ACC_EN ? in_first : 1'b1)});
  assign last_d  = L'({last_q, (ACC_EN ? in_last : 1'b1)});

  for (genvar k = 1; k <= L; k++) begin : g_lvl
    localparam int unsigned CI   = lvl_cnt(k - 1);
    localparam int unsigned CO   = lvl_cnt(k);
    localparam int unsigned WO   = DATA_WID + k;
    localparam int unsigned OOFF = lvl_off(k);

    logic signed [WO-2:0] op [CI];

    if (k == 1) begin : g_src
      for (genvar i = 0; i < CI; i++) begin : g_op
        assign op[i] = IN[i];
      end
    end else begin : g_src
      localparam int unsigned IOFF = lvl_off(k - 1);
      for (genvar i = 0; i < CI; i++) begin : g_op
        assign op[i] = tree_q[IOFF + i*(WO-1) +: WO-1];
      end
    end

    // Pair operands in index order; an odd leftover passes through sign-extended.
    for (genvar j = 0; j < CO; j++) begin : g_node
      logic signed [WO-1:0] sum_c;
      if (2*j + 1 < CI) begin : g_pair
        assign sum_c = WO'(op[2*j]) + WO'(op[2*j+1]);
      end else begin : g_pass
        assign sum_c = WO'(op[2*j]);
      end
      assign tree_d[OOFF + j*WO +: WO] = vld_d[k-1] ? sum_c : tree_q[OOFF + j*WO +: WO];
    end
  end

  assign tree_sum = tree_q[lvl_off(L) +: TW];

  // Accumulate, reduce to DATA_WID and stage the result.
  always_comb begin
    acc_next_c = first_q[L-1] ? AW'(tree_sum) : acc_q + AW'(tree_sum);
    wrap_c     = acc_next_c[DATA_WID-1:0];
    res_c      = wrap_c;
    res_ovf_c  = (AW'(wrap_c) != acc_next_c);
    if (SAT) begin
      if (acc_next_c > MAX_V) begin
        res_c = MAX_V[DATA_WID-1:0];
      end else if (acc_next_c < MIN_V) begin
        res_c = MIN_V[DATA_WID-1:0];
      end
    end
    acc_d       = acc_q;
    out_valid_d = 1'b0;
    out_d       = out_q;
    out_ovf_d   = out_ovf_q;
    if (vld_q[L-1]) begin
      acc_d = acc_next_c;
      if (last_q[L-1]) begin
        out_valid_d = 1'b1;
        out_d       = res_c;
        out_ovf_d   = res_ovf_c;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q       <= '0;
      first_q     <= '0;
      last_q      <= '0;
      tree_q      <= '0;
      acc_q       <= '0;
      out_valid_q <= 1'b0;
      out_q       <= '0;
      out_ovf_q   <= 1'b0;
    end else if (!stall) begin
      vld_q       <= vld_d;
      first_q     <= first_d;
      last_q      <= last_d;
      tree_q      <= tree_d;
      acc_q       <= acc_d;
      out_valid_q <= out_valid_d;
      out_q       <= out_d;
      out_ovf_q   <= out_ovf_d;
    end
  end

  assign out_valid = out_valid_q;
  assign OUT       = out_q;
  assign out_ovf   = out_ovf_q;

endmodule

// File: tb/tb_adder_tree_pipe.sv
// Directed bench for adder_tree_pipe: wrap/saturate, accumulation, stall,
// mid-group reset and a non-power-of-two operand count.
module tb_adder_tree_pipe;

  logic clk = 1'b0;
  logic rst, stall, in_valid, in_first, in_last;
  logic signed [15:0] in8 [0:7];
  logic signed [15:0] in5 [0:4];

  logic        w_vld, w_ovf, s_vld, s_ovf, f_vld, f_ovf;
  logic [15:0] w_out, s_out, f_out;

  int errors = 0;
  int checks = 0;
  logic        mon_en = 1'b0;
  logic [15:0] got [$];

  always #5 clk = ~clk;

  adder_tree_pipe #(.DATA_WID(16), .INPUT_NUM(8), .SAT(1'b0), .ACC_EN(1'b0), .ACC_GUARD(8)) u_w (
    .clk(clk), .rst(rst), .stall(stall), .in_valid(in_valid), .in_first(in_first),
    .in_last(in_last), .IN(in8), .out_valid(w_vld), .OUT(w_out), .out_ovf(w_ovf));

  adder_tree_pipe #(.DATA_WID(16), .INPUT_NUM(8), .SAT(1'b1), .ACC_EN(1'b1), .ACC_GUARD(8)) u_s (
    .clk(clk), .rst(rst), .stall(stall), .in_valid(in_valid), .in_first(in_first),
    .in_last(in_last), .IN(in8), .out_valid(s_vld), .OUT(s_out), .out_ovf(s_ovf));

  adder_tree_pipe #(.DATA_WID(16), .INPUT_NUM(5), .SAT(1'b1), .ACC_EN(1'b1), .ACC_GUARD(8)) u_5 (
    .clk(clk), .rst(rst), .stall(stall), .in_valid(in_valid), .in_first(in_first),
    .in_last(in_last), .IN(in5), .out_valid(f_vld), .OUT(f_out), .out_ovf(f_ovf));

  // Results consumed by downstream: out_valid high and no stall at the edge.
  always @(posedge clk) begin
    if (mon_en && s_vld && !stall) got.push_back(s_out);
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic fill8(input logic [15:0] v);
    for (int i = 0; i < 8; i++) in8[i] = v;
  endtask

  task automatic beat(input logic f, input logic l);
    in_valid = 1'b1;
    in_first = f;
    in_last  = l;
  endtask

  task automatic idle();
    in_valid = 1'b0;
    in_first = 1'b0;
    in_last  = 1'b0;
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0;
    idle();
    fill8(16'h0000);
    for (int i = 0; i < 5; i++) in5[i] = 16'sd0;
    tick();
    tick();
    chk("rst_vld", 32'(s_vld), 32'd0);
    chk("rst_out", 32'(s_out), 32'd0);
    chk("rst_ovf", 32'(s_ovf), 32'd0);
    rst = 1'b0;
    tick();

    // Single beat, wrap mode, latency and one-cycle valid pulse
    fill8(16'h00aa);
    in8[0] = 16'h0001;
    beat(1'b1, 1'b1);
    tick();
    idle();
    chk("lat_e0", 32'(w_vld), 32'd0);
    tick();
    chk("lat_e1", 32'(w_vld), 32'd0);
    tick();
    chk("lat_e2", 32'(w_vld), 32'd0);
    tick();
    chk("a_vld", 32'(w_vld), 32'd1);
    chk("a_out", 32'(w_out), 32'h04a7);
    chk("a_ovf", 32'(w_ovf), 32'd0);
    tick();
    chk("a_pulse", 32'(w_vld), 32'd0);

    // Positive overflow: saturate vs wrap
    in8 = '{16'h00aa, 16'hffaa, 16'h0008, 16'h0005, 16'h6544, 16'h4545, 16'h3452, 16'h2424};
    beat(1'b1, 1'b1);
    tick();
    idle();
    repeat (3) tick();
    chk("b_sat_out", 32'(s_out), 32'h7fff);
    chk("b_sat_ovf", 32'(s_ovf), 32'd1);
    chk("b_wrap_out", 32'(w_out), 32'h0360);
    chk("b_wrap_ovf", 32'(w_ovf), 32'd1);

    // Negative overflow
    fill8(16'ha00a);
    beat(1'b1, 1'b1);
    tick();
    idle();
    repeat (3) tick();
    chk("c_sat_vld", 32'(s_vld), 32'd1);
    chk("c_sat_out", 32'(s_out), 32'h8000);
    chk("c_sat_ovf", 32'(s_ovf), 32'd1);
    chk("c_wrap_out", 32'(w_out), 32'h0050);
    chk("c_wrap_ovf", 32'(w_ovf), 32'd1);

    // Three-beat accumulation group
    fill8(16'h0010);
    beat(1'b1, 1'b0);
    tick();
    chk("d_e0", 32'(s_vld), 32'd0);
    beat(1'b0, 1'b0);
    tick();
    chk("d_e1", 32'(s_vld), 32'd0);
    beat(1'b0, 1'b1);
    tick();
    chk("d_e2", 32'(s_vld), 32'd0);
    idle();
    tick();
    chk("d_e3", 32'(s_vld), 32'd0);
    tick();
    chk("d_e4", 32'(s_vld), 32'd0);
    tick();
    chk("d_vld", 32'(s_vld), 32'd1);
    chk("d_out", 32'(s_out), 32'h0180);
    chk("d_ovf", 32'(s_ovf), 32'd0);
    tick();
    chk("d_pulse", 32'(s_vld), 32'd0);

    // Back-to-back single-beat groups with a two-cycle stall while a result is held
    mon_en = 1'b1;
    for (int g = 0; g < 4; g++) begin
      fill8(16'(g + 1));
      beat(1'b1, 1'b1);
      tick();
    end
    idle();
    stall = 1'b1;
    tick();
    chk("e_hold_vld", 32'(s_vld), 32'd1);
    chk("e_hold_out", 32'(s_out), 32'h0008);
    tick();
    stall = 1'b0;
    repeat (6) tick();
    mon_en = 1'b0;
    chk("e_count", 32'(got.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("e_res%0d", i), (i < got.size()) ? 32'(got[i]) : 32'hdeadbeef, 32'(8 * (i + 1)));
    end

    // Reset in the middle of a group discards the open partial
    fill8(16'h0100);
    beat(1'b1, 1'b0);
    tick();
    idle();
    rst = 1'b1;
    tick();
    chk("f_rst_vld", 32'(s_vld), 32'd0);
    rst = 1'b0;
    fill8(16'h0002);
    beat(1'b0, 1'b1);
    tick();
    idle();
    tick();
    tick();
    chk("f_early", 32'(s_vld), 32'd0);
    tick();
    chk("f_vld", 32'(s_vld), 32'd1);
    chk("f_out", 32'(s_out), 32'h0010);
    chk("f_ovf", 32'(s_ovf), 32'd0);

    // Five operands, odd leftovers at several levels
    in5 = '{16'sd1, 16'sd2, 16'sd3, 16'sd4, 16'sd5};
    beat(1'b1, 1'b1);
    tick();
    idle();
    tick();
    tick();
    chk("g_early", 32'(f_vld), 32'd0);
    tick();
    chk("g_vld", 32'(f_vld), 32'd1);
    chk("g_out", 32'(f_out), 32'd15);
    chk("g_ovf", 32'(f_ovf), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
